// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter, 7/8 data bits, optional parity, 1 stop.
// Define UART_TX_FIFO_EN to queue up to FIFO_DEPTH bytes instead of one holding register.
module uart_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       tx_sample_pulse,
    input  logic       data_bits,
    input  logic       parity_en,
    input  logic       parity_odd0_even1,
    input  logic       tx_data_reg_wr,
    input  logic [7:0] tx_data,
    output logic       UART_TX,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       overflow
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0] state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       bits8_q, bits8_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic       line_q, line_d;
    logic       ovf_q, ovf_d;

    logic       st_valid;
    logic [7:0] st_data;
    logic       wr_acc;
    logic       take;
    logic       push;
    logic       pop;
    logic [7:0] pend_data;
    logic [7:0] load_data;
    logic       bit_end;
    logic [2:0] last_bit;

    // An idle transmitter with nothing stored takes the written byte directly.
    assign wr_acc    = tx_data_reg_wr & tx_ready;
    assign take      = (state_q == S_IDLE) & (st_valid | wr_acc);
    assign pop       = take & st_valid;
    assign push      = wr_acc & ~(take & ~st_valid);
    assign pend_data = st_valid ? st_data : tx_data;
    assign load_data = data_bits ? pend_data : {1'b0, pend_data[6:0]};
    assign bit_end   = tx_sample_pulse & (tick_q == 4'd15);
    assign last_bit  = bits8_q ? 3'd7 : 3'd6;

`ifdef UART_TX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        full;

    assign full     = (wptr_q[AW] != rptr_q[AW]) &&
                      (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign st_valid = (wptr_q != rptr_q);
    assign st_data  = mem_q[rptr_q[AW-1:0]];
    assign tx_ready = ~full;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        if (pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push) mem_q[wptr_q[AW-1:0]] <= tx_data;
        end
    end
`else
    logic       hold_valid_q, hold_valid_d;
    logic [7:0] hold_q, hold_d;
    logic       unused_depth;

    assign unused_depth = (FIFO_DEPTH != 0);
    assign st_valid     = hold_valid_q;
    assign st_data      = hold_q;
    assign tx_ready     = ~hold_valid_q;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (pop) hold_valid_d = 1'b0;
        if (push) begin
            hold_valid_d = 1'b1;
            hold_d       = tx_data;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        bits8_d   = bits8_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        if (tx_sample_pulse) tick_d = tick_q + 4'd1;
        unique case (state_q)
            S_IDLE: begin
                tick_d = '0;
                bit_d  = '0;
                if (take) begin
                    state_d   = S_START;
                    shift_d   = load_data;
                    bits8_d   = data_bits;
                    par_en_d  = parity_en;
                    par_bit_d = (^load_data) ^ ~parity_odd0_even1;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == last_bit) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    always_comb begin
        line_d = 1'b1;
        unique case (state_q)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_q[0];
            S_PARITY: line_d = par_bit_q;
            default:  line_d = 1'b1;
        endcase
    end

    assign ovf_d = tx_data_reg_wr & ~tx_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            bits8_q   <= 1'b1;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            line_q    <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            bits8_q   <= bits8_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            line_q    <= line_d;
            ovf_q     <= ovf_d;
        end
    end

    assign UART_TX  = line_q;
    assign overflow = ovf_q;
    assign tx_busy  = (state_q != S_IDLE) | st_valid;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: vector table, corner sequences and randomized bursts
// checked by a frame-level line decoder against expected frames.
`timescale 1ns/1ps
module tb_uart_tx;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       ACLK = 1'b0;
    logic       ARESETn = 1'b0;
    logic       tx_sample_pulse = 1'b0;
    logic       data_bits = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd0_even1 = 1'b0;
    logic       tx_data_reg_wr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       UART_TX;
    logic       tx_ready;
    logic       tx_busy;
    logic       overflow;

    uart_tx #(.FIFO_DEPTH(4)) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .tx_sample_pulse(tx_sample_pulse),
        .data_bits(data_bits),
        .parity_en(parity_en),
        .parity_odd0_even1(parity_odd0_even1),
        .tx_data_reg_wr(tx_data_reg_wr),
        .tx_data(tx_data),
        .UART_TX(UART_TX),
        .tx_ready(tx_ready),
        .tx_busy(tx_busy),
        .overflow(overflow)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [7:0] d;
        logic       b8;
        logic       pe;
        logic       ev;
    } frm_t;

    typedef struct {
        logic [7:0] d;
        logic       b8;
        logic       pe;
        logic       ev;
        int         len;
        logic       par;
    } vec_t;

    frm_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   pulse_div = 1;
    bit   pulse_on = 1'b1;
    int   frames_rx = 0;
    int   frames_exp = 0;
    bit   mon_act = 1'b0;
    logic last_par = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic int frame_len(input frm_t f);
        return 2 + (f.b8 ? 8 : 7) + (f.pe ? 1 : 0);
    endfunction

    // Line levels of one frame, slot 0 = start bit.
    function automatic logic [11:0] frame_bits(input frm_t f);
        logic [11:0] v;
        int nd;
        int ones;
        int p;
        v = '0;
        nd = f.b8 ? 8 : 7;
        ones = 0;
        for (int i = 0; i < nd; i++) begin
            v[i+1] = f.d[i];
            if (f.d[i]) ones++;
        end
        p = nd + 1;
        if (f.pe) begin
            v[p] = f.ev ? (ones % 2 == 1) : (ones % 2 == 0);
            p++;
        end
        v[p] = 1'b1;
        return v;
    endfunction

    initial forever begin
        @(posedge ACLK);
        #1;
        tx_sample_pulse = pulse_on &&
            ($urandom_range(pulse_div - 1, 0) == 0);
    end

    // Line decoder: finds the start edge, samples each bit mid-period.
    initial begin
        int          cnt;
        int          n;
        logic [11:0] got;
        logic [11:0] exp;
        bit          valid;
        frm_t        f;
        cnt = 0; n = 10; got = '0; exp = '0; valid = 0;
        f = '{8'h00, 1'b1, 1'b0, 1'b0};
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                mon_act = 0;
                exp_q.delete();
            end else if (!mon_act) begin
                if (UART_TX == 1'b0) begin
                    mon_act = 1;
                    cnt = tx_sample_pulse ? 1 : 0;
                    got = '0;
                    chk("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() == 0) begin
                        valid = 0;
                        n = 10;
                    end else begin
                        f = exp_q.pop_front();
                        valid = 1;
                        n = frame_len(f);
                        exp = frame_bits(f);
                    end
                end
            end else if (tx_sample_pulse) begin
                cnt++;
                if (cnt % 16 == 8) begin
                    got[cnt/16] = UART_TX;
                    if (cnt / 16 == n - 1) begin
                        mon_act = 0;
                        frames_rx++;
                        if (valid) begin
                            chk("frame_bits", got, exp);
                            if (f.pe) last_par = got[n-2];
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] d);
        frm_t f;
        f.d = d;
        f.b8 = data_bits;
        f.pe = parity_en;
        f.ev = parity_odd0_even1;
        exp_q.push_back(f);
        frames_exp++;
    endtask

    task automatic wr1(input logic [7:0] d);
        expect_frame(d);
        @(posedge ACLK);
        #1;
        tx_data_reg_wr = 1'b1;
        tx_data = d;
        @(posedge ACLK);
        #1;
        tx_data_reg_wr = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((tx_busy || mon_act) && k < 30000) begin
            @(negedge ACLK);
            k++;
        end
        chk("idle_timeout", k < 30000, 1);
        chk("frames_left", exp_q.size(), 0);
        tick(3);
    endtask

    task automatic busy_len(output int len);
        len = 0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge ACLK);
            if (!tx_busy) break;
            len++;
            if (len == 50) begin
                parity_odd0_even1 = ~parity_odd0_even1;
                data_bits = ~data_bits;
            end
        end
    endtask

    task automatic burst(input int len, input bit fixed);
        int ovf;
        int stored;
        ovf = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge ACLK);
            #1;
            tx_data_reg_wr = 1'b1;
            tx_data = fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            if (i < CAP + 1) expect_frame(tx_data);
            @(negedge ACLK);
            ovf += int'(overflow);
        end
        @(posedge ACLK);
        #1;
        tx_data_reg_wr = 1'b0;
        @(negedge ACLK);
        ovf += int'(overflow);
        stored = (len - 1 < CAP) ? len - 1 : CAP;
        chk("ready_after_burst", tx_ready, stored < CAP);
        @(negedge ACLK);
        ovf += int'(overflow);
        chk("overflow_count", ovf, (len > CAP + 1) ? len - CAP - 1 : 0);
    endtask

    initial begin
        vec_t tbl[7];
        int   len;
        int   lowc;
        int   chg;
        int   bl;
        logic l0;

        tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 160, 1'b0};
        tbl[1] = '{8'hC3, 1'b0, 1'b1, 1'b1, 160, 1'b1};
        tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 176, 1'b1};
        tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 176, 1'b0};
        tbl[4] = '{8'h7F, 1'b0, 1'b1, 1'b0, 160, 1'b0};
        tbl[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 144, 1'b0};
        tbl[6] = '{8'hA5, 1'b1, 1'b1, 1'b0, 176, 1'b1};

        tick(3);
        chk("rst_line", UART_TX, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ovf", overflow, 0);
        ARESETn = 1'b1;
        tick(2);

        // Start latency and start-bit width, 8N1 with a pulse every cycle.
        data_bits = 1'b1;
        parity_en = 1'b0;
        expect_frame(8'h55);
        @(posedge ACLK);
        #1;
        tx_data_reg_wr = 1'b1;
        tx_data = 8'h55;
        @(negedge ACLK);
        chk("lat_n_busy", tx_busy, 0);
        chk("lat_n_line", UART_TX, 1);
        @(posedge ACLK);
        #1;
        tx_data_reg_wr = 1'b0;
        @(negedge ACLK);
        chk("lat_n1_busy", tx_busy, 1);
        chk("lat_n1_line", UART_TX, 1);
        @(negedge ACLK);
        chk("lat_n2_line", UART_TX, 0);
        lowc = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge ACLK);
            if (UART_TX != 1'b0) break;
            lowc++;
        end
        chk("start_width", lowc, 16);
        wait_idle();

        for (int i = 0; i < 7; i++) begin
            data_bits = tbl[i].b8;
            parity_en = tbl[i].pe;
            parity_odd0_even1 = tbl[i].ev;
            wr1(tbl[i].d);
            busy_len(len);
            chk($sformatf("busy_len_%0d", i), len, tbl[i].len);
            wait_idle();
            if (tbl[i].pe) chk($sformatf("parity_%0d", i), last_par, tbl[i].par);
        end

        // Over-full burst: one in shift, CAP stored, the rest dropped.
        data_bits = 1'b1;
        parity_en = 1'b0;
        parity_odd0_even1 = 1'b0;
        burst(CAP + 2, 1'b1);
        wait_idle();

        // Reset in the middle of data bit 3 of 0x96 (bit 3 is 0).
        wr1(8'h96);
        tick(70);
        chk("pre_reset_line", UART_TX, 0);
        ARESETn = 1'b0;
        #1;
        chk("mid_rst_line", UART_TX, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        frames_exp--;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        tick(2);
        wr1(8'h3C);
        wait_idle();

        // Pulses withheld mid-frame: line and busy must hold.
        parity_en = 1'b1;
        parity_odd0_even1 = 1'b1;
        wr1(8'h96);
        tick(40);
        pulse_on = 1'b0;
        tick(2);
        l0 = UART_TX;
        chg = 0;
        bl = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge ACLK);
            if (UART_TX != l0) chg++;
            if (!tx_busy) bl++;
        end
        chk("hold_line_changes", chg, 0);
        chk("hold_busy_low", bl, 0);
        pulse_on = 1'b1;
        wait_idle();

        for (int r = 0; r < 10; r++) begin
            pulse_div = $urandom_range(3, 1);
            data_bits = 1'($urandom);
            parity_en = 1'($urandom);
            parity_odd0_even1 = 1'($urandom);
            burst($urandom_range(CAP + 2, 1), 1'b0);
            wait_idle();
        end

        chk("frames_total", frames_rx, frames_exp);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
